serial_to_parallel_buf: RTL and testbench
=========================================

Name: serial_to_parallel_buf

Overview:
- Parametrised successor to the UART byte-to-word assembler.
- Collects N/8 bytes from the UART receiver into an N-bit word and presents it on a valid/ready output port held in a one-word output register.
- Adds configurable byte order, a partial-word flush, receive back-pressure and a sticky overrun flag.
- Sits between uart_rx and the RSA operand loader.

Parameters:
- N, 32, output word width; must be a multiple of 8 and at least 16.
- MSB_FIRST, 1. 1 = first byte received lands in bits [N-1:N-8]. 0 = first byte lands in bits [7:0].
- TIMEOUT, 1024, idle cycles before a partial word is discarded. Used only with S2P_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- rx_valid  in  1  byte strobe from UART receiver
- rx_byte  in  8  received byte
- rx_ready  out  1  block can accept a byte this cycle
- flush  in  1  single-cycle pulse: emit the current partial word
- err_clr  in  1  clears rx_overrun
- tx_bytes  out  N  assembled word
- tx_nbytes  out  CNT_W  number of valid bytes in tx_bytes, where CNT_W = clog2(N/8+1)
- tx_valid  out  1  tx_bytes/tx_nbytes valid
- tx_ready  in  1  consumer accepts the word
- rx_overrun  out  1  sticky: a byte was offered while rx_ready=0

Behaviour:
- Reset (rst_n=0, async):
  - Byte index = 0, shift/assembly register = 0, flush_pend = 0.
  - Outputs: tx_bytes=0, tx_nbytes=0, tx_valid=0, rx_overrun=0, rx_ready=1.
- Derived values: NBYTES = N/8; idx counts 0..NBYTES-1.
- Byte accept: on rx_valid && rx_ready, the byte is written to slot idx and idx increments.
  - With MSB_FIRST=1, slot k occupies bits [N-1-8k : N-8-8k]. With MSB_FIRST=0, slot k occupies bits [8k+7 : 8k].
- Word completion: accepting the byte at idx=NBYTES-1 loads the output register on the same edge.
  - tx_valid=1 the cycle after the last byte (latency 1).
  - tx_nbytes=NBYTES; idx wraps to 0; the assembly register clears to 0.
- Output register holds tx_bytes/tx_nbytes stable while tx_valid && !tx_ready. It is released on tx_valid && tx_ready.
- out_free = !tx_valid || tx_ready.
- rx_ready = 1 except when idx=NBYTES-1 and !out_free. Non-final bytes are always accepted, so the next word assembles while the previous one is held.
- Same-cycle load and drain: tx_ready and a final byte in the same cycle is legal. The new word replaces the old with no bubble.
- Flush:
  - A flush pulse sets flush_pend.
  - When flush_pend && idx>0 && out_free, the partial word goes to the output register: unfilled slots are 0 and tx_nbytes=idx. idx then returns to 0 and flush_pend clears.
  - Flush with idx=0 clears flush_pend and emits nothing.
  - A byte accepted in the same cycle as a flush executes is included in the flushed word (the byte is applied first).
  - If that byte completes the word, it becomes a normal full word and flush_pend clears.
- Overrun: rx_valid && !rx_ready drops the byte, leaves idx unchanged and sets rx_overrun. err_clr clears it. If err_clr and a new overrun occur together, set wins.
- Reset mid-word or with tx_valid=1 discards all data immediately.

Optional Feature:
- S2P_TIMEOUT_EN defined:
  - An idle counter increments each cycle while idx>0 and no byte is accepted. It resets on any accepted byte or when idx=0.
  - When the count reaches TIMEOUT-1, idx returns to 0, the assembly register clears, and the 1-cycle output pulse rx_timeout (extra port, out, 1) is asserted.
  - A pending flush takes priority over timeout in the same cycle.
- S2P_TIMEOUT_EN undefined: no counter and no rx_timeout port; a partial word is held indefinitely.

Decomposition:
- Shared package/header s2p_pkg:
  - BYTE_W=8 constant.
  - clog2 function used for CNT_W and the timeout counter width.
- One natural sub-module, s2p_idle_timer: the TIMEOUT counter, instantiated only under S2P_TIMEOUT_EN.
- Byte-slot placement stays in the top module.

Test Plan:
- N=32, MSB_FIRST=1, tx_ready=1, bytes AA,BB,CC,DD on consecutive cycles -> one cycle after DD: tx_valid=1, tx_bytes=AABBCCDD, tx_nbytes=4; next cycle tx_valid=0.
- MSB_FIRST=0, same bytes -> tx_bytes=DDCCBBAA.
- Back-pressure with tx_ready=0:
  - Send 8 bytes 01..08 -> first word 01020304 held stable.
  - Bytes 05,06,07 accepted; rx_ready=0 while 08 is offered.
  - Raise tx_ready -> 08 accepted in the same cycle; next cycle tx_bytes=05060708.
- Overflow during stall: offer 08 while rx_ready=0 -> byte dropped, rx_overrun=1 and stays 1 until an err_clr pulse, then 0.
- Partial flush:
  - Bytes 11,22 then a flush pulse -> tx_bytes=11220000, tx_nbytes=2.
  - Flush with idx=0 -> no tx_valid.
  - Flush in the same cycle as byte 33 after 11,22 -> tx_bytes=11223300, tx_nbytes=3.
- Reset and timeout:
  - Assert rst_n=0 after 2 bytes with tx_valid=1 -> outputs 0 immediately; a following 4-byte sequence assembles cleanly.
  - With S2P_TIMEOUT_EN and TIMEOUT=8: byte AA then 8 idle cycles -> rx_timeout pulse; next 4 bytes form a clean word.

Source files
------------

// File: rtl/s2p_pkg.sv
// Shared constants and helpers for the serial-to-parallel word buffer.
package s2p_pkg;

  localparam int BYTE_W = 8;

  // Ceiling log2, usable in constant expressions; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/s2p_idle_timer.sv
// Idle timer for a partially assembled word: down-counter that fires after
// TIMEOUT consecutive active cycles. Only instantiated with S2P_TIMEOUT_EN.
module s2p_idle_timer
  import s2p_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_active,
  output logic o_expire
);

  localparam int TW = (clog2(TIMEOUT) < 1) ? 1 : clog2(TIMEOUT);
  localparam logic [TW-1:0] RELOAD = TW'(TIMEOUT - 1);

  logic [TW-1:0] r_cnt;
  logic          w_tc;

  assign w_tc     = (r_cnt == '0);
  assign o_expire = i_active && w_tc;

  // Reload whenever idle stops or the count expires, so each run starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= RELOAD;
    end else if (!i_active || w_tc) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/serial_to_parallel_buf.sv
// Assembles UART bytes into N-bit words behind a one-word valid/ready output
// register, with flush, back-pressure and overrun. S2P_TIMEOUT_EN adds idle discard.
module serial_to_parallel_buf
  import s2p_pkg::*;
#(
  parameter int N         = 32,
  parameter int MSB_FIRST = 1,
  parameter int TIMEOUT   = 1024,
  localparam int CNT_W    = clog2(N / BYTE_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_valid,
  input  logic [7:0]       rx_byte,
  output logic             rx_ready,
  input  logic             flush,
  input  logic             err_clr,
  output logic [N-1:0]     tx_bytes,
  output logic [CNT_W-1:0] tx_nbytes,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             rx_overrun
`ifdef S2P_TIMEOUT_EN
  ,
  output logic             rx_timeout
`endif
);

  localparam int NBYTES = N / BYTE_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(NBYTES);

  if (N % BYTE_W != 0 || N < 16) begin : g_bad_width
    $error("serial_to_parallel_buf: N must be a multiple of 8 and >= 16");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("serial_to_parallel_buf: TIMEOUT must be >= 1");
  end

  logic [CNT_W-1:0] r_idx;
  logic [N-1:0]     r_asm;
  logic             r_flush_pend;
  logic [N-1:0]     r_out;
  logic [CNT_W-1:0] r_out_nb;
  logic             r_out_vld;
  logic             r_overrun;

  logic             w_out_free;
  logic             w_rx_ready;
  logic             w_accept;
  logic             w_complete;
  logic [CNT_W-1:0] w_pos;
  logic [CNT_W+2:0] w_base;
  logic [N-1:0]     w_asm_wr;
  logic [CNT_W-1:0] w_idx_wr;
  logic             w_flush_go;
  logic             w_flush_done;
  logic             w_load;
  logic             w_timeout;

  assign w_out_free = !r_out_vld || tx_ready;
  // Only the final byte waits for the output register; earlier bytes always land.
  assign w_rx_ready = !((r_idx == LAST) && !w_out_free);
  assign w_accept   = rx_valid && w_rx_ready;
  assign w_complete = w_accept && (r_idx == LAST);
  assign w_idx_wr   = w_accept ? r_idx + 1'b1 : r_idx;

  assign w_pos  = (MSB_FIRST != 0) ? (LAST - r_idx) : r_idx;
  assign w_base = {w_pos, 3'b000};

  always_comb begin
    w_asm_wr = r_asm;
    if (w_accept) w_asm_wr[w_base +: BYTE_W] = rx_byte;
  end

  // The byte of this cycle is applied before a pending flush is evaluated.
  assign w_flush_go   = r_flush_pend && !w_complete && (w_idx_wr != '0) && w_out_free;
  assign w_flush_done = r_flush_pend && (w_complete || (w_idx_wr == '0) || w_out_free);
  assign w_load       = w_complete || w_flush_go;

`ifdef S2P_TIMEOUT_EN
  logic w_expire;
  logic r_timeout;

  s2p_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_active ((r_idx != '0) && !w_accept),
    .o_expire (w_expire)
  );

  assign w_timeout = w_expire && !r_flush_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_timeout <= 1'b0;
    else        r_timeout <= w_timeout;
  end

  assign rx_timeout = r_timeout;
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_asm <= '0;
    end else if (w_load || w_timeout) begin
      r_idx <= '0;
      r_asm <= '0;
    end else begin
      r_idx <= w_idx_wr;
      r_asm <= w_asm_wr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out     <= '0;
      r_out_nb  <= '0;
      r_out_vld <= 1'b0;
    end else if (w_load) begin
      r_out     <= w_asm_wr;
      r_out_nb  <= w_complete ? FULL : w_idx_wr;
      r_out_vld <= 1'b1;
    end else if (r_out_vld && tx_ready) begin
      r_out_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_pend <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_flush_pend <= flush || (r_flush_pend && !w_flush_done);
      if (rx_valid && !w_rx_ready) r_overrun <= 1'b1;
      else if (err_clr)            r_overrun <= 1'b0;
    end
  end

  assign rx_ready   = w_rx_ready;
  assign tx_bytes   = r_out;
  assign tx_nbytes  = r_out_nb;
  assign tx_valid   = r_out_vld;
  assign rx_overrun = r_overrun;

endmodule

// File: tb/tb_serial_to_parallel_buf.sv
// Self-checking bench: MSB-first and LSB-first instances driven in parallel and
// compared every cycle against a queue-based model of the word buffer.
module tb_serial_to_parallel_buf;

  localparam int N       = 32;
  localparam int NB      = N / 8;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        flush;
  logic        err_clr;
  logic        tx_ready;

  logic        m_rx_ready, l_rx_ready;
  logic [N-1:0] m_tx_bytes, l_tx_bytes;
  logic [2:0]  m_tx_nbytes, l_tx_nbytes;
  logic        m_tx_valid, l_tx_valid;
  logic        m_rx_overrun, l_rx_overrun;
`ifdef S2P_TIMEOUT_EN
  logic        m_rx_timeout, l_rx_timeout;
`endif

  always #5 clk = ~clk;

  serial_to_parallel_buf #(.N(N), .MSB_FIRST(1), .TIMEOUT(TIMEOUT)) u_msb (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .rx_ready(m_rx_ready), .flush(flush), .err_clr(err_clr),
    .tx_bytes(m_tx_bytes), .tx_nbytes(m_tx_nbytes), .tx_valid(m_tx_valid),
    .tx_ready(tx_ready), .rx_overrun(m_rx_overrun)
`ifdef S2P_TIMEOUT_EN
    , .rx_timeout(m_rx_timeout)
`endif
  );

  serial_to_parallel_buf #(.N(N), .MSB_FIRST(0), .TIMEOUT(TIMEOUT)) u_lsb (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .rx_ready(l_rx_ready), .flush(flush), .err_clr(err_clr),
    .tx_bytes(l_tx_bytes), .tx_nbytes(l_tx_nbytes), .tx_valid(l_tx_valid),
    .tx_ready(tx_ready), .rx_overrun(l_rx_overrun)
`ifdef S2P_TIMEOUT_EN
    , .rx_timeout(l_rx_timeout)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]   m_part[$];
  bit           m_vld;
  logic [N-1:0] m_word_msb, m_word_lsb;
  int           m_nb;
  bit           m_pend;
  bit           m_ovr;
  int           m_idle;
  bit           m_tmo;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] pack(input bit msb);
    logic [N-1:0] w;
    w = '0;
    for (int k = 0; k < m_part.size(); k++) begin
      if (msb) w[(NB-1-k)*8 +: 8] = m_part[k];
      else     w[k*8 +: 8]        = m_part[k];
    end
    return w;
  endfunction

  task automatic emit();
    m_word_msb = pack(1'b1);
    m_word_lsb = pack(1'b0);
    m_nb       = m_part.size();
    m_vld      = 1'b1;
    m_part.delete();
  endtask

  task automatic model_reset();
    m_part.delete();
    m_vld = 0; m_word_msb = '0; m_word_lsb = '0; m_nb = 0;
    m_pend = 0; m_ovr = 0; m_idle = 0; m_tmo = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_tx_valid", {31'd0, m_tx_valid}, '0);
    check("rst_tx_bytes", m_tx_bytes, '0);
    check("rst_tx_nbytes", {29'd0, m_tx_nbytes}, '0);
    check("rst_overrun", {31'd0, m_rx_overrun}, '0);
    check("rst_rx_ready", {31'd0, m_rx_ready}, 32'd1);
    check("rst_lsb_tx_valid", {31'd0, l_tx_valid}, '0);
    check("rst_lsb_tx_bytes", l_tx_bytes, '0);
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input bit v, input logic [7:0] b, input bit fl, input bit ec, input bit tr);
    bit exp_rdy, free, acc, nonempty, pend_before, tmo;
    rx_valid = v; rx_byte = b; flush = fl; err_clr = ec; tx_ready = tr;
    #1;
    exp_rdy = !(m_part.size() == NB-1 && m_vld && !tr);
    check("rx_ready_msb", {31'd0, m_rx_ready}, {31'd0, exp_rdy});
    check("rx_ready_lsb", {31'd0, l_rx_ready}, {31'd0, exp_rdy});
    check("tx_valid_msb", {31'd0, m_tx_valid}, {31'd0, m_vld});
    check("tx_valid_lsb", {31'd0, l_tx_valid}, {31'd0, m_vld});
    if (m_vld) begin
      check("tx_bytes_msb", m_tx_bytes, m_word_msb);
      check("tx_bytes_lsb", l_tx_bytes, m_word_lsb);
      check("tx_nbytes_msb", {29'd0, m_tx_nbytes}, m_nb);
      check("tx_nbytes_lsb", {29'd0, l_tx_nbytes}, m_nb);
    end
    check("overrun_msb", {31'd0, m_rx_overrun}, {31'd0, m_ovr});
    check("overrun_lsb", {31'd0, l_rx_overrun}, {31'd0, m_ovr});
`ifdef S2P_TIMEOUT_EN
    check("timeout_msb", {31'd0, m_rx_timeout}, {31'd0, m_tmo});
    check("timeout_lsb", {31'd0, l_rx_timeout}, {31'd0, m_tmo});
`endif
    free        = !m_vld || tr;
    pend_before = m_pend;
    nonempty    = m_part.size() > 0;
    acc         = v && exp_rdy;
    if (m_vld && tr) m_vld = 0;
    if (v && !exp_rdy) m_ovr = 1;
    else if (ec)       m_ovr = 0;
    if (acc) m_part.push_back(b);
    if (m_part.size() == NB) begin
      emit();
      m_pend = 0;
    end else if (m_pend) begin
      if (m_part.size() == 0) m_pend = 0;
      else if (free) begin emit(); m_pend = 0; end
    end
    tmo = 0;
`ifdef S2P_TIMEOUT_EN
    if (nonempty && !acc) begin
      if (m_idle == TIMEOUT-1) begin
        m_idle = 0;
        if (!pend_before) begin m_part.delete(); tmo = 1; end
      end else m_idle++;
    end else m_idle = 0;
`else
    if (nonempty && pend_before && tmo) m_idle = 0;
`endif
    if (fl) m_pend = 1;
    @(posedge clk);
    @(negedge clk);
    m_tmo = tmo;
  endtask

  task automatic idle(input int n, input bit tr);
    for (int i = 0; i < n; i++) cycle(0, 8'h00, 0, 0, tr);
  endtask

  initial begin
    rst_n = 0; rx_valid = 0; rx_byte = 0; flush = 0; err_clr = 0; tx_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst_n = 1;
    @(negedge clk);

    // Full word, both byte orders
    cycle(1, 8'hAA, 0, 0, 1);
    cycle(1, 8'hBB, 0, 0, 1);
    cycle(1, 8'hCC, 0, 0, 1);
    cycle(1, 8'hDD, 0, 0, 1);
    check("const_msb_word", m_tx_bytes, 32'hAABBCCDD);
    check("const_lsb_word", l_tx_bytes, 32'hDDCCBBAA);
    idle(2, 1);

    // Back-pressure and overrun
    for (int i = 1; i <= 7; i++) cycle(1, 8'(i), 0, 0, 0);
    check("held_word", m_tx_bytes, 32'h01020304);
    cycle(1, 8'h08, 0, 0, 0);
    cycle(1, 8'h08, 0, 1, 0);
    check("overrun_set_wins", {31'd0, m_rx_overrun}, 32'd1);
    cycle(1, 8'h08, 0, 0, 1);
    check("second_word", m_tx_bytes, 32'h05060708);
    idle(2, 1);
    cycle(0, 8'h00, 0, 1, 1);
    idle(1, 1);

    // Flush
    cycle(1, 8'h11, 0, 0, 1);
    cycle(1, 8'h22, 0, 0, 1);
    cycle(0, 8'h00, 1, 0, 1);
    idle(3, 1);
    cycle(0, 8'h00, 1, 0, 1);
    idle(3, 1);
    cycle(1, 8'h11, 0, 0, 1);
    cycle(1, 8'h22, 0, 0, 1);
    cycle(1, 8'h33, 1, 0, 1);
    idle(3, 1);

    // Reset mid-word with a held output word
    for (int i = 0; i < 6; i++) cycle(1, 8'(8'h40 + i), 0, 0, 0);
    rst_n = 0;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge clk);
    rst_n = 1;
    cycle(1, 8'h5A, 0, 0, 1);
    cycle(1, 8'h6B, 0, 0, 1);
    cycle(1, 8'h7C, 0, 0, 1);
    cycle(1, 8'h8D, 0, 0, 1);
    idle(2, 1);

    // Idle partial word (discarded only when the timeout is built in)
    cycle(1, 8'hAA, 0, 0, 1);
    idle(10, 1);
    cycle(1, 8'h01, 0, 0, 1);
    cycle(1, 8'h02, 0, 0, 1);
    cycle(1, 8'h03, 0, 0, 1);
    cycle(1, 8'h04, 0, 0, 1);
    idle(3, 1);
    cycle(0, 8'h00, 1, 0, 1);
    idle(3, 1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 9) < 7), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 1) == 1));
    end
    idle(4, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
